// File: rtl/mips_pkg.sv
// Shared MIPS core types: word addresses, fetch FSM states and the reset vector.
package mips_pkg;

    typedef logic [29:0] word_addr_t;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit and imem.
interface ifetch_unit_if;

    logic                  imem_req;
    mips_pkg::word_addr_t  imem_addr;
    logic                  imem_gnt;
    logic                  imem_rvalid;
    logic [31:0]           imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/if_slot.sv
// IF/ID output register: captures fetched words, empties when consumed,
// clears on redirect and holds while the hazard unit stalls.
module if_slot
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        capture,
    input  logic        flush,
    input  logic        stall,
    input  word_addr_t  capture_pc,
    input  logic [31:0] capture_instr,
    output logic        slot_valid,
    output word_addr_t  slot_pc,
    output logic [31:0] slot_instr
);

    // A flush only drops the valid bit; pc/instr keep their last contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= 1'b0;
            slot_pc    <= '0;
            slot_instr <= '0;
        end else if (flush) begin
            slot_valid <= 1'b0;
        end else if (capture) begin
            slot_valid <= 1'b1;
            slot_pc    <= capture_pc;
            slot_instr <= capture_instr;
        end else if (!stall) begin
            slot_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Fetch front end: PC register, single-outstanding imem request FSM and
// the IF/ID slot, with stall hold and redirect flush.
module ifetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
    input  logic               clk,
    input  logic               rst,
    input  word_addr_t         npc,
    input  logic               redirect,
    input  logic               stall,
    output word_addr_t         PC,
    ifetch_unit_if.master      imem,
    output logic               if_valid,
    output word_addr_t         if_pc,
    output logic [31:0]        if_instr
);

    fetch_state_t state;
    logic         accept;
    logic         capture;

    // Request only from ISSUE, and never while a stalled instruction occupies IF/ID.
    assign imem.imem_req  = !rst && (state == ISSUE) && !(if_valid && stall);
    assign imem.imem_addr = PC;

    assign accept  = imem.imem_req && imem.imem_gnt;
    assign capture = (state == WAIT) && imem.imem_rvalid && !redirect;

    // DROP absorbs the response of a request that a redirect made stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ISSUE;
        end else begin
            case (state)
                ISSUE: begin
                    if (accept) begin
                        state <= redirect ? DROP : WAIT;
                    end
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        state <= ISSUE;
                    end else if (redirect) begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (imem.imem_rvalid) begin
                        state <= ISSUE;
                    end
                end
                default: state <= ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            PC <= RESET_PC[31:2];
        end else if (redirect || capture) begin
            PC <= npc;
        end
    end

    if_slot u_slot (
        .clk           (clk),
        .rst           (rst),
        .capture       (capture),
        .flush         (redirect),
        .stall         (stall),
        .capture_pc    (PC),
        .capture_instr (imem.imem_rdata),
        .slot_valid    (if_valid),
        .slot_pc       (if_pc),
        .slot_instr    (if_instr)
    );

endmodule
